// File: rtl/y86_regfile_pipe.sv
// Y86-64 pipeline register file: two read ports, E/M write ports, write-to-read
// bypass, per-register busy scoreboard and optional registered read.
module y86_regfile_pipe #(
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       NREG     = 15,
  parameter int unsigned       SP_IDX   = 4,
  parameter logic [DATA_W-1:0] SP_INIT  = '0,
  parameter int unsigned       BYPASS   = 1,
  parameter int unsigned       READ_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_reg,
  output logic              hazA,
  output logic              hazB
);

  localparam logic BYP_ON = (BYPASS != 0);

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;

  // Register array; M port is applied last so it wins when dstE==dstM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
      end
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (dstM == ADDR_W'(i)) begin
          regs[i] <= valM;
        end else if (dstE == ADDR_W'(i)) begin
          regs[i] <= valE;
        end
      end
    end
  end

  // Scoreboard; a new reservation outranks a completing write on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (rsv_en && (rsv_reg == ADDR_W'(i))) begin
          busy[i] <= 1'b1;
        end else if (wr_en && ((dstE == ADDR_W'(i)) || (dstM == ADDR_W'(i)))) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [ADDR_W-1:0] src;
    logic [DATA_W-1:0] rd_c;
    logic              hz_c;
    logic              found;
    logic              hit_e;
    logic              hit_m;

    assign src = (p == 0) ? srcA : srcB;

    // Out-of-range and RNONE IDs never match, so they read 0 with no hazard.
    always_comb begin
      rd_c  = '0;
      hz_c  = 1'b0;
      found = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        if (src == ADDR_W'(i)) begin
          rd_c  = regs[i];
          hz_c  = busy[i];
          found = 1'b1;
        end
      end
      hit_e = found && BYP_ON && wr_en && (dstE == src);
      hit_m = found && BYP_ON && wr_en && (dstM == src);
      if (hit_m) begin
        rd_c = valM;
      end else if (hit_e) begin
        rd_c = valE;
      end
      if (hit_e || hit_m) begin
        hz_c = 1'b0;
      end
    end
  end

  assign hazA = g_port[0].hz_c;
  assign hazB = g_port[1].hz_c;

  if (READ_LAT != 0) begin : g_rd_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valA <= '0;
        valB <= '0;
      end else begin
        valA <= g_port[0].rd_c;
        valB <= g_port[1].rd_c;
      end
    end
  end else begin : g_rd_comb
    assign valA = g_port[0].rd_c;
    assign valB = g_port[1].rd_c;
  end

endmodule
